// File: rtl/dcache_plru_array.sv
// Per-set 8-way tree-PLRU store: updates on every hit/fill, answers lookups one cycle later.
// Single-cycle lookup latency, no backpressure; same-set update+lookup returns the updated tree.
module dcache_plru_array #(
  parameter  int NUM_SETS = 16,
  localparam int S_IDX    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [S_IDX-1:0] lookup_set,
  input  logic             update_valid,
  input  logic [S_IDX-1:0] update_set,
  input  logic [2:0]       update_way,
  input  logic [7:0]       way_valid_i,
  output logic             resp_valid,
  output logic [6:0]       plru_bits_o,
  output logic [2:0]       victim_way_o
);

  logic [6:0] tree_q [NUM_SETS];
  logic [6:0] tree_d;
  logic [6:0] rd_tree;
  logic       resp_q;
  logic [6:0] plru_q;
  logic [2:0] tree_victim;
  logic [2:0] inv_victim;

  // Point every node on the accessed path away from the accessed way.
  always_comb begin
    tree_d    = tree_q[update_set];
    tree_d[0] = ~update_way[2];
    if (update_way[2]) tree_d[2] = ~update_way[1];
    else               tree_d[1] = ~update_way[1];
    tree_d[{1'b0, update_way[2:1]} + 3'd3] = ~update_way[0];
  end

  // Write-first bypass so a same-cycle update is visible to the lookup.
  always_comb begin
    rd_tree = tree_q[lookup_set];
    if (update_valid && (update_set == lookup_set)) rd_tree = tree_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= 7'b0;
      resp_q <= 1'b0;
      plru_q <= 7'b0;
    end else begin
      if (update_valid) tree_q[update_set] <= tree_d;
      if (lookup_valid) begin
        resp_q <= 1'b1;
        plru_q <= rd_tree;
      end else begin
        resp_q <= 1'b0;
      end
    end
  end

  always_comb begin
    tree_victim    = 3'd0;
    tree_victim[2] = plru_q[0];
    tree_victim[1] = plru_q[0] ? plru_q[2] : plru_q[1];
    tree_victim[0] = plru_q[{1'b0, tree_victim[2:1]} + 3'd3];
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    inv_victim = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!way_valid_i[i]) inv_victim = 3'(i);
    end
  end

  assign resp_valid   = resp_q;
  assign plru_bits_o  = plru_q;
  assign victim_way_o = (way_valid_i != 8'hFF) ? inv_victim : tree_victim;

endmodule

// File: tb/tb_dcache_plru_array.sv
// Directed bench for dcache_plru_array: hand-computed vectors plus a small tree model.
module tb_dcache_plru_array;

  logic       clk;
  logic       rst;
  logic       lookup_valid;
  logic [3:0] lookup_set;
  logic       update_valid;
  logic [3:0] update_set;
  logic [2:0] update_way;
  logic [7:0] way_valid_i;
  logic       resp_valid;
  logic [6:0] plru_bits_o;
  logic [2:0] victim_way_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [6:0] mdl [16];

  dcache_plru_array #(.NUM_SETS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_set   (lookup_set),
    .update_valid (update_valid),
    .update_set   (update_set),
    .update_way   (update_way),
    .way_valid_i  (way_valid_i),
    .resp_valid   (resp_valid),
    .plru_bits_o  (plru_bits_o),
    .victim_way_o (victim_way_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] m_touch(input logic [6:0] t, input int w);
    logic [6:0] r;
    r    = t;
    r[0] = (w < 4);
    if (w < 4) r[1] = (w < 2);
    else       r[2] = (w < 6);
    r[3 + w / 2] = (w % 2 == 0);
    return r;
  endfunction

  function automatic logic [2:0] m_victim(input logic [6:0] t, input logic [7:0] v);
    logic [2:0] r;
    logic       found;
    found = 1'b0;
    r     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!found && !v[i]) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      if (!t[0]) r = t[1] ? (t[4] ? 3'd3 : 3'd2) : (t[3] ? 3'd1 : 3'd0);
      else       r = t[2] ? (t[6] ? 3'd7 : 3'd6) : (t[5] ? 3'd5 : 3'd4);
    end
    return r;
  endfunction

  task automatic idle();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    lookup_valid = 1'b0;
    lookup_set   = '0;
    update_valid = 1'b0;
    update_set   = '0;
    update_way   = '0;
    way_valid_i  = 8'hFF;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    n_cmp++;
    if (plru_bits_o !== 7'b0) begin
      n_fail++; $display("FAIL reset_plru got=%b exp=0000000", plru_bits_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_lookup();
    way_valid_i  = 8'hFF;
    lookup_valid = 1'b1;
    lookup_set   = 4'd3;
    @(negedge clk);
    idle();
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL t1_resp_valid got=%b exp=1", resp_valid);
    end
    n_cmp++;
    if (plru_bits_o !== 7'b0000000) begin
      n_fail++; $display("FAIL t1_plru got=%b exp=0000000", plru_bits_o);
    end
    n_cmp++;
    if (victim_way_o !== 3'd0) begin
      n_fail++; $display("FAIL t1_victim got=%0d exp=0", victim_way_o);
    end
  endtask

  task automatic test_update();
    update_valid = 1'b1; update_set = 4'd3; update_way = 3'd0;
    @(negedge clk);
    update_valid = 1'b0;
    lookup_valid = 1'b1; lookup_set = 4'd3;
    @(negedge clk);
    lookup_valid = 1'b0;
    n_cmp++;
    if (plru_bits_o !== 7'b0001011) begin
      n_fail++; $display("FAIL t2_plru_w0 got=%b exp=0001011", plru_bits_o);
    end
    n_cmp++;
    if (victim_way_o !== 3'd4) begin
      n_fail++; $display("FAIL t2_victim_w0 got=%0d exp=4", victim_way_o);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL t2_resp_drop got=%b exp=0", resp_valid);
    end
    n_cmp++;
    if (plru_bits_o !== 7'b0001011) begin
      n_fail++; $display("FAIL t2_plru_hold got=%b exp=0001011", plru_bits_o);
    end
    update_valid = 1'b1; update_set = 4'd3; update_way = 3'd4;
    @(negedge clk);
    update_valid = 1'b0;
    lookup_valid = 1'b1; lookup_set = 4'd3;
    @(negedge clk);
    lookup_valid = 1'b0;
    n_cmp++;
    if (plru_bits_o !== 7'b0101110) begin
      n_fail++; $display("FAIL t2_plru_w4 got=%b exp=0101110", plru_bits_o);
    end
    n_cmp++;
    if (victim_way_o !== 3'd2) begin
      n_fail++; $display("FAIL t2_victim_w4 got=%0d exp=2", victim_way_o);
    end
  endtask

  task automatic test_invalid_way();
    lookup_valid = 1'b1; lookup_set = 4'd3;
    @(negedge clk);
    lookup_valid = 1'b0;
    way_valid_i = 8'b1111_0111;
    #1;
    n_cmp++;
    if (victim_way_o !== 3'd3) begin
      n_fail++; $display("FAIL t3_invalid_way3 got=%0d exp=3", victim_way_o);
    end
    way_valid_i = 8'h00;
    #1;
    n_cmp++;
    if (victim_way_o !== 3'd0) begin
      n_fail++; $display("FAIL t3_all_invalid got=%0d exp=0", victim_way_o);
    end
    way_valid_i = 8'hFF;
    #1;
    n_cmp++;
    if (victim_way_o !== 3'd2) begin
      n_fail++; $display("FAIL t3_all_valid got=%0d exp=2", victim_way_o);
    end
  endtask

  task automatic test_same_cycle();
    lookup_valid = 1'b1; lookup_set = 4'd5;
    update_valid = 1'b1; update_set = 4'd5; update_way = 3'd7;
    @(negedge clk);
    n_cmp++;
    if (plru_bits_o !== 7'b0000000) begin
      n_fail++; $display("FAIL t4_bypass_w7 got=%b exp=0000000", plru_bits_o);
    end
    n_cmp++;
    if (victim_way_o !== 3'd0) begin
      n_fail++; $display("FAIL t4_victim_w7 got=%0d exp=0", victim_way_o);
    end
    lookup_set = 4'd6; update_set = 4'd5; update_way = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || plru_bits_o !== 7'b0000000) begin
      n_fail++; $display("FAIL t4_other_set got=%b/%b exp=1/0000000", resp_valid, plru_bits_o);
    end
    // From 0001011, touching way 3 clears b1 and b4: 0001001, victim way 4.
    lookup_set = 4'd5; update_set = 4'd5; update_way = 3'd3;
    @(negedge clk);
    update_valid = 1'b0;
    n_cmp++;
    if (plru_bits_o !== 7'b0001001) begin
      n_fail++; $display("FAIL t4_bypass_w3 got=%b exp=0001001", plru_bits_o);
    end
    n_cmp++;
    if (victim_way_o !== 3'd4) begin
      n_fail++; $display("FAIL t4_victim_w3 got=%0d exp=4", victim_way_o);
    end
    @(negedge clk);
    lookup_valid = 1'b0;
    n_cmp++;
    if (plru_bits_o !== 7'b0001001) begin
      n_fail++; $display("FAIL t4_stored got=%b exp=0001001", plru_bits_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_t;
    logic [2:0] exp_v;
    int         s;
    int         w;
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) mdl[k] = 7'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      s = i % 16;
      w = (i * 5 + 1) % 8;
      lookup_valid = 1'b1;
      lookup_set   = 4'(s);
      update_valid = (i > 0);
      update_set   = 4'((i + 15) % 16);
      update_way   = 3'(w);
      way_valid_i  = (i % 4 == 3) ? (8'hFF ^ (8'h01 << (i % 8))) : 8'hFF;
      exp_t = mdl[s];
      exp_v = m_victim(exp_t, way_valid_i);
      @(negedge clk);
      if (i > 0) mdl[(i + 15) % 16] = m_touch(mdl[(i + 15) % 16], w);
      n_cmp++;
      if (resp_valid !== 1'b1 || plru_bits_o !== exp_t || victim_way_o !== exp_v) begin
        n_fail++;
        $display("FAIL t5_stream i=%0d got=%b/%b/%0d exp=1/%b/%0d",
                 i, resp_valid, plru_bits_o, victim_way_o, exp_t, exp_v);
      end
    end
    idle();
    way_valid_i = 8'hFF;
  endtask

  task automatic test_reset_midflight();
    lookup_valid = 1'b1; lookup_set = 4'd1;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || plru_bits_o !== mdl[1]) begin
      n_fail++; $display("FAIL t6_pre got=%b/%b exp=1/%b", resp_valid, plru_bits_o, mdl[1]);
    end
    lookup_set = 4'd2;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || plru_bits_o !== 7'b0) begin
      n_fail++; $display("FAIL t6_async got=%b/%b exp=0/0000000", resp_valid, plru_bits_o);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0 || plru_bits_o !== 7'b0) begin
      n_fail++; $display("FAIL t6_dropped got=%b/%b exp=0/0000000", resp_valid, plru_bits_o);
    end
    #1;
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL t6_after_release got=%b exp=0", resp_valid);
    end
    for (int k = 0; k < 16; k++) begin
      lookup_valid = 1'b1;
      lookup_set   = 4'(k);
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || plru_bits_o !== 7'b0) begin
        n_fail++; $display("FAIL t6_cleared set=%0d got=%b/%b exp=1/0000000", k, resp_valid, plru_bits_o);
      end
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_lookup();
    test_update();
    test_invalid_way();
    test_same_cycle();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
